// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO registers.
// MULTU: 32-cycle shift-add, LSB first. DIVU: 32-cycle restoring division, MSB first.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam logic [3:0] OP_MULTU = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MFHI  = 4'd9;
  localparam logic [3:0] OP_MFLO  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        dz_q;

  // multiply datapath
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic [63:0] acc;
  logic [63:0] acc_nxt;

  // divide datapath; q starts as the dividend and fills with quotient bits
  logic [32:0] rem;
  logic [31:0] q;
  logic [31:0] divisor;
  logic [31:0] dividend;
  logic [33:0] shifted;
  logic [33:0] diff;
  logic [32:0] rem_nxt;
  logic [31:0] q_nxt;

  // one shift-add and one restoring-division step, evaluated every cycle
  always_comb begin
    acc_nxt = acc + (mplr[0] ? mcand : 64'd0);
    shifted = {rem, q[31]};
    diff    = shifted - {2'b00, divisor};
    if (diff[33]) begin
      rem_nxt = shifted[32:0];
      q_nxt   = {q[30:0], 1'b0};
    end else begin
      rem_nxt = diff[32:0];
      q_nxt   = {q[30:0], 1'b1};
    end
  end

  // control FSM plus iteration registers and HI/LO write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      dz_q     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      mcand    <= 64'd0;
      mplr     <= 32'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      q        <= 32'd0;
      divisor  <= 32'd0;
      dividend <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          dz_q <= 1'b0;
          if (start && alu_ctrl == OP_MULTU) begin
            mcand <= {32'd0, a};
            mplr  <= b;
            acc   <= 64'd0;
            cnt   <= 6'd0;
            state <= MUL;
          end else if (start && alu_ctrl == OP_DIVU) begin
            q        <= a;
            dividend <= a;
            divisor  <= b;
            rem      <= 33'd0;
            cnt      <= 6'd0;
            state    <= DIV;
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi    <= acc_nxt[63:32];
            lo    <= acc_nxt[31:0];
            state <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            if (divisor == 32'd0) begin
              lo   <= 32'hFFFF_FFFF;
              hi   <= dividend;
              dz_q <= 1'b1;
            end else begin
              lo <= q_nxt;
              hi <= rem_nxt[31:0];
            end
            state <= DONE;
          end
        end
        default: begin
          dz_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == MUL) || (state == DIV);
  assign done     = (state == DONE);
  assign div_zero = dz_q;

  // move-from mux; reads the committed HI/LO even while an operation runs
  always_comb begin
    case (alu_ctrl)
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high; clock port is clk, reset port is rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only with alu_ctrl.
REQ-005 alu_ctrl  input  4  ALU control code from control unit: 7=MULTU, 8=DIVU, 9=MFHI, 10=MFLO; all other codes are no-ops for this block.
REQ-006 a  input  32  operand rs (multiplicand / dividend), unsigned.
REQ-007 b  input  32  operand rt (multiplier / divisor), unsigned.
REQ-008 busy  output  1  operation in progress; high in MUL and DIV states.
REQ-009 done  output  1  one-cycle pulse: HI/LO hold the new result.
REQ-010 div_zero  output  1  one-cycle pulse coincident with done when DIVU divisor was 0.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.
REQ-013 result  output  32  move-from value for the register file write-back path.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-015 In IDLE, start=1 with alu_ctrl=7 SHALL latch a, b, clear the 6-bit iteration counter, and enter MUL at the next edge (accept edge).
REQ-016 In IDLE, start=1 with alu_ctrl=8 SHALL latch a, b, clear the counter, and enter DIV at the accept edge.
REQ-017 start with any other alu_ctrl, or start in MUL/DIV/DONE, SHALL be ignored without state or register change.
REQ-018 Operands SHALL be taken only from the latched copies after the accept edge; later changes on a/b have no effect.
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per cycle, LSB first, with a 64-bit accumulator; the product is exact unsigned 32x32->64.
REQ-020 DIV SHALL be iterative restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
REQ-021 MUL and DIV SHALL each last exactly 32 cycles; the counter increments each cycle and the 32nd iteration edge moves the FSM to DONE.
REQ-022 On the edge entering DONE, hi/lo SHALL be written: MULTU hi=product[63:32], lo=product[31:0]; DIVU lo=quotient, hi=remainder.
REQ-023 DIVU with b=0 SHALL still take 32 cycles, then write lo=32'hFFFF_FFFF and hi=a; div_zero=1 in DONE.
REQ-024 done SHALL be 1 only in DONE, which lasts exactly one cycle, then returns to IDLE. Latency: accept edge at cycle 0 gives done high in cycle 33.
REQ-025 busy SHALL be 0 in IDLE and DONE; start is accepted again from the cycle after DONE.
REQ-026 hi and lo SHALL change only on the DONE-entry edge or on reset; they hold their values otherwise.
REQ-027 result SHALL be combinational: hi when alu_ctrl=9, lo when alu_ctrl=10, else 32'd0.
REQ-028 result SHALL reflect the pre-operation hi/lo while busy; stalling MFHI/MFLO on busy is the pipeline's responsibility.

Reset
REQ-029 rst=1 SHALL force next state IDLE; clear hi, lo, counter and internal accumulator/remainder to 0; drive busy=0, done=0, div_zero=0 from the following cycle.
REQ-030 rst asserted during MUL/DIV SHALL abort the operation: no done pulse, and no partial result reaches hi/lo.
REQ-031 rst SHALL take priority over a coincident start.

Verification
REQ-032 MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> busy cycles 1-32, done in cycle 33, hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-033 DIVU a=100, b=7 -> done in cycle 33, lo=14, hi=2, div_zero=0.
REQ-034 DIVU a=5, b=0 -> done in cycle 33, div_zero=1, lo=32'hFFFF_FFFF, hi=5.
REQ-035 MULTU 3x4 accepted; start with DIVU 9/3 in cycle 5 -> ignored, hi=0, lo=12, exactly one done pulse.
REQ-036 MULTU accepted, rst=1 in cycle 10 -> busy=0 from cycle 11, hi=lo=0, no done pulse ever.
REQ-037 MULTU a=32'h0001_0000, b=32'h0001_0000, then alu_ctrl=9 -> result=1; alu_ctrl=10 -> result=0; alu_ctrl=2 -> result=0.
